// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory subsystem.
// The arbiter connects through the slave modport; whatever drives the requests
// and models the memory (a CPU/DMA wrapper or a bench) uses the master modport.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  // Requester handshake: valid/we/addr/wdata are held stable by the requester
  // until ready pulses for one cycle; ready means "accepted and strobed to
  // memory". done pulses once per accepted access, err qualifies done (timeout),
  // and rdata holds the last read result until the next read completes on that port.
  logic                  req0_valid, req1_valid;
  logic                  req0_we, req1_we;
  logic [ADDR_WIDTH-1:0] req0_addr, req1_addr;
  logic [DATA_WIDTH-1:0] req0_wdata, req1_wdata;
  logic                  req0_ready, req1_ready;
  logic                  req0_done, req1_done;
  logic                  req0_err, req1_err;
  logic [DATA_WIDTH-1:0] req0_rdata, req1_rdata;

  // Memory side: one-cycle command strobes, registered address/data.
  logic                  mem_rd_enable, mem_wr_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we,
    input  req0_addr, req1_addr, req0_wdata, req1_wdata,
    output req0_ready, req1_ready, req0_done, req1_done,
    output req0_err, req1_err, req0_rdata, req1_rdata,
    output mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data,
    input  mem_busy, mem_rd_data
  );

  modport master (
    output req0_valid, req1_valid, req0_we, req1_we,
    output req0_addr, req1_addr, req0_wdata, req1_wdata,
    input  req0_ready, req1_ready, req0_done, req1_done,
    input  req0_err, req1_err, req0_rdata, req1_rdata,
    input  mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data,
    output mem_busy, mem_rd_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants one read or write at a time to port 0 (CPU)
// or port 1 (DMA/loader), strobes the memory for one cycle, waits for mem_busy
// to clear (or times out), returns read data and pulses done.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// without it port 0 always wins a tie and no last-grant register exists.
module mem_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  mem_arbiter_if.slave        bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // WAIT lasts at most TIMEOUT_CYCLES cycles: the counter starts at 0 in the
  // first WAIT cycle, so the abort fires when it has reached TIMEOUT_CYCLES-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  winner_q;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  logic [15:0]           cnt_q;
  logic                  grant_any;
  logic                  grant_port;
  logic                  timeout_hit;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  last_q;
`endif

  // Arbitration: pick the port to grant when the FSM is idle.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (bus.req0_valid && bus.req1_valid) grant_port = ~last_q;
    else                                  grant_port = ~bus.req0_valid;
`else
    grant_port = ~bus.req0_valid;
`endif
  end

  assign timeout_hit = (state_q == ST_WAIT) && bus.mem_busy && (cnt_q >= TO_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (!bus.mem_busy || timeout_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command latch, timeout counter, error flag and per-port read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      winner_q <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            winner_q <= grant_port;
            we_q     <= grant_port ? bus.req1_we    : bus.req0_we;
            addr_q   <= grant_port ? bus.req1_addr  : bus.req0_addr;
            wdata_q  <= grant_port ? bus.req1_wdata : bus.req0_wdata;
            err_q    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q   <= grant_port;
`endif
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          if (!bus.mem_busy) begin
            // Writes never touch the read-data holding registers.
            if (!we_q) begin
              if (winner_q) rdata1_q <= bus.mem_rd_data;
              else          rdata0_q <= bus.mem_rd_data;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM outputs: strobes and ready in ISSUE, done/err in DONE, for the winner only.
  always_comb begin
    bus.req0_ready    = (state_q == ST_ISSUE) && !winner_q;
    bus.req1_ready    = (state_q == ST_ISSUE) &&  winner_q;
    bus.mem_rd_enable = (state_q == ST_ISSUE) && !we_q;
    bus.mem_wr_enable = (state_q == ST_ISSUE) &&  we_q;
    bus.req0_done     = (state_q == ST_DONE)  && !winner_q;
    bus.req1_done     = (state_q == ST_DONE)  &&  winner_q;
    bus.req0_err      = (state_q == ST_DONE)  && !winner_q && err_q;
    bus.req1_err      = (state_q == ST_DONE)  &&  winner_q && err_q;
    bus.mem_addr      = addr_q;
    bus.mem_wr_data   = wdata_q;
    bus.req0_rdata    = rdata0_q;
    bus.req1_rdata    = rdata1_q;
    dbg_state_o       = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (TIMEOUT_CYCLES = 10). Directed accesses on both ports
// against a small memory responder. Expected memory commands go to cmd_q and
// expected completions to exp_q when a request is issued; a negedge monitor
// pops and compares whenever the arbiter strobes memory or pulses done.
// Build with +define+MEM_ARB_ROUND_ROBIN_EN to expect round-robin tie breaking.
module tb_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TO = 10;
  localparam int W  = 26;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc;
  int         checks;
  int         errors;
  int         ready_cyc;
  int         busy_cycles;
  bit         busy_stuck;
  logic [DW-1:0] mem [0:65535];

  // cmd entry: {port, we, addr[15:0], wdata[7:0]}
  logic [W-1:0] cmd_q[$];
  // completion entry: {port, err, rdata0[7:0], rdata1[7:0], latency_from_ready[7:0]}
  logic [W-1:0] exp_q[$];

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory responder ----------------
  initial begin
    logic [AW-1:0] a;
    bus.mem_busy    = 1'b0;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_enable || bus.mem_wr_enable) begin
        a = bus.mem_addr;
        if (bus.mem_wr_enable) mem[a] = bus.mem_wr_data;
        bus.mem_rd_data = 8'hEE;
        if (busy_stuck || busy_cycles > 0) begin
          @(posedge clk); #1 bus.mem_busy = 1'b1;
          if (busy_stuck) begin
            while (busy_stuck) @(posedge clk);
          end else begin
            repeat (busy_cycles) @(posedge clk);
          end
          #1 bus.mem_busy = 1'b0;
        end
        bus.mem_rd_data = mem[a];
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] expv;
    logic [7:0]   lat8;
    bit           shape_ok;
    forever begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready || bus.mem_rd_enable || bus.mem_wr_enable) begin
        act       = {bus.req1_ready, bus.mem_wr_enable, bus.mem_addr, bus.mem_wr_data};
        shape_ok  = (bus.mem_rd_enable ^ bus.mem_wr_enable) && (bus.req0_ready ^ bus.req1_ready);
        ready_cyc = cyc;
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got cmd %h at cycle %0d, required no command", act, cyc);
        end else begin
          expv = cmd_q.pop_front();
          if (act !== expv || !shape_ok) begin
            errors++;
            $display("FAIL cmd: got port %0d we %0d addr %h wdata %h (rd %0d wr %0d rdy0 %0d rdy1 %0d), required port %0d we %0d addr %h wdata %h",
                     act[25], act[24], act[23:8], act[7:0], bus.mem_rd_enable, bus.mem_wr_enable,
                     bus.req0_ready, bus.req1_ready, expv[25], expv[24], expv[23:8], expv[7:0]);
          end
        end
      end
      if (bus.req0_done || bus.req1_done || bus.req0_err || bus.req1_err) begin
        lat8     = 8'(cyc - ready_cyc);
        act      = {bus.req1_done, (bus.req1_done ? bus.req1_err : bus.req0_err),
                    bus.req0_rdata, bus.req1_rdata, lat8};
        shape_ok = (bus.req0_done ^ bus.req1_done) &&
                   !(bus.req0_err && !bus.req0_done) && !(bus.req1_err && !bus.req1_done);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done0 %0d done1 %0d at cycle %0d, required no completion",
                   bus.req0_done, bus.req1_done, cyc);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv || !shape_ok) begin
            errors++;
            $display("FAIL done: got port %0d err %0d rdata0 %h rdata1 %h lat %0d (done0 %0d done1 %0d err0 %0d err1 %0d), required port %0d err %0d rdata0 %h rdata1 %h lat %0d",
                     act[25], act[24], act[23:16], act[15:8], act[7:0],
                     bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err,
                     expv[25], expv[24], expv[23:16], expv[15:8], expv[7:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic void exp_cmd(input logic p, input logic we, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
    cmd_q.push_back({p, we, a, d});
  endfunction

  function automatic void exp_done(input logic p, input logic err, input logic [DW-1:0] r0,
                                   input logic [DW-1:0] r1, input logic [7:0] lat);
    exp_q.push_back({p, err, r0, r1, lat});
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endfunction

  // Present one request, hold it until ready, drop (or hand over) at T+2.
  task automatic drive(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    if (p == 0) begin
      bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_valid = 1'b1;
    end
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if ((p == 0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: port %0d got no ready, required within 300 cycles", p);
    end
    @(posedge clk); #1;
    if (p == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending completions, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_handshake"}, {24'd0, bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done,
                             bus.req0_err, bus.req1_err, bus.mem_rd_enable, bus.mem_wr_enable}, 32'd0);
    chk({tag, "_rdata0"}, {24'd0, bus.req0_rdata}, 32'd0);
    chk({tag, "_rdata1"}, {24'd0, bus.req1_rdata}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_mem_wr_data"}, {24'd0, bus.mem_wr_data}, 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    cyc = 0; checks = 0; errors = 0; ready_cyc = 0;
    busy_cycles = 0; busy_stuck = 1'b0;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    mem[16'h00FF] = 8'h3C;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");
    @(posedge clk); #1;

    // Port 0 write 0xA5 to 0x1234, then read it back, memory never busy.
    exp_cmd(1'b0, 1'b1, 16'h1234, 8'hA5);
    exp_done(1'b0, 1'b0, 8'h00, 8'h00, 8'd2);
    drive(0, 1'b1, 16'h1234, 8'hA5);
    wait_drain();
    exp_cmd(1'b0, 1'b0, 16'h1234, 8'h00);
    exp_done(1'b0, 1'b0, 8'hA5, 8'h00, 8'd2);
    drive(0, 1'b0, 16'h1234, 8'h00);
    wait_drain();

    // Port 1 read 0x00FF with busy high for 5 cycles: done 7 cycles after ready.
    busy_cycles = 5;
    exp_cmd(1'b1, 1'b0, 16'h00FF, 8'h00);
    exp_done(1'b1, 1'b0, 8'hA5, 8'h3C, 8'd7);
    drive(1, 1'b0, 16'h00FF, 8'h00);
    wait_drain();

    // Write then read on port 1: the write leaves rdata1 at 0x3C.
    busy_cycles = 0;
    exp_cmd(1'b1, 1'b1, 16'h0042, 8'h5A);
    exp_done(1'b1, 1'b0, 8'hA5, 8'h3C, 8'd2);
    drive(1, 1'b1, 16'h0042, 8'h5A);
    wait_drain();
    busy_cycles = 2;
    exp_cmd(1'b1, 1'b0, 16'h0042, 8'h00);
    exp_done(1'b1, 1'b0, 8'hA5, 8'h5A, 8'd4);
    drive(1, 1'b0, 16'h0042, 8'h00);
    wait_drain();
    busy_cycles = 0;

    // Both ports valid continuously, 4 writes each.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      exp_cmd(1'b0, 1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i));
      exp_done(1'b0, 1'b0, 8'hA5, 8'h5A, 8'd2);
      exp_cmd(1'b1, 1'b1, 16'h0200 + 16'(i), 8'h20 + 8'(i));
      exp_done(1'b1, 1'b0, 8'hA5, 8'h5A, 8'd2);
    end
`else
    for (int i = 0; i < 4; i++) begin
      exp_cmd(1'b0, 1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i));
      exp_done(1'b0, 1'b0, 8'hA5, 8'h5A, 8'd2);
    end
    for (int i = 0; i < 4; i++) begin
      exp_cmd(1'b1, 1'b1, 16'h0200 + 16'(i), 8'h20 + 8'(i));
      exp_done(1'b1, 1'b0, 8'hA5, 8'h5A, 8'd2);
    end
`endif
    fork
      begin
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i));
      end
      begin
        for (int i = 0; i < 4; i++) drive(1, 1'b1, 16'h0200 + 16'(i), 8'h20 + 8'(i));
      end
    join
    wait_drain();

    // Timeout: busy stuck, done+err 11 cycles after ISSUE, rdata0 kept.
    busy_stuck = 1'b1;
    exp_cmd(1'b0, 1'b0, 16'h1234, 8'h00);
    exp_done(1'b0, 1'b1, 8'hA5, 8'h5A, 8'd11);
    drive(0, 1'b0, 16'h1234, 8'h00);
    wait_drain();
    busy_stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_cmd(1'b0, 1'b0, 16'h0101, 8'h00);
    exp_done(1'b0, 1'b0, 8'h11, 8'h5A, 8'd2);
    drive(0, 1'b0, 16'h0101, 8'h00);
    wait_drain();

    // Reset during WAIT: no done, everything zero, then port 1 served.
    busy_stuck = 1'b1;
    exp_cmd(1'b0, 1'b0, 16'h1234, 8'h00);
    drive(0, 1'b0, 16'h1234, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_in_wait");
    busy_stuck = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abandoned_no_done", {31'd0, (exp_q.size() == 0 && cmd_q.size() == 0)}, 32'd1);
    @(posedge clk); #1;
    busy_cycles = 1;
    exp_cmd(1'b1, 1'b0, 16'h00FF, 8'h00);
    exp_done(1'b1, 1'b0, 8'h00, 8'h3C, 8'd3);
    drive(1, 1'b0, 16'h00FF, 8'h00);
    wait_drain();

    chk("cmd_queue_empty", cmd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
